// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM state type for the multi-cycle ALU.
package alu_pkg;

    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_DIV  = 3'b011;
    localparam logic [2:0] OP_MOD  = 3'b100;
    localparam logic [2:0] OP_SHL  = 3'b101;
    localparam logic [2:0] OP_SHR  = 3'b110;
    localparam logic [2:0] OP_GT   = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        DONE
    } state_t;

endpackage

// File: rtl/alu_mc_if.sv
// Request/response bundle of alu_mc: valid/ready request in, valid/ready result out.
interface alu_mc_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   result;
    logic             zero;
    logic             div0;

    modport master (
        output in_valid, a, b, sel, out_ready,
        input  in_ready, out_valid, result, zero, div0
    );

    modport slave (
        input  in_valid, a, b, sel, out_ready,
        output in_ready, out_valid, result, zero, div0
    );
endinterface

// File: rtl/alu_div.sv
// Restoring shift-subtract divider: one quotient bit per cycle, WIDTH cycles total.
module alu_div #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;

    // One restoring step: shift the next dividend bit into the remainder and
    // subtract when it fits. The remainder never exceeds the divisor, so the
    // W-bit difference is exact once the extra shifted-out bit is compared.
    function automatic logic [2*WIDTH-1:0] div_step(
        input logic [WIDTH-1:0] rem,
        input logic [WIDTH-1:0] quo,
        input logic [WIDTH-1:0] dvs
    );
        logic [WIDTH:0] shifted;
        shifted = {rem, quo[WIDTH-1]};
        if (shifted >= {1'b0, dvs})
            return {shifted[WIDTH-1:0] - dvs, quo[WIDTH-2:0], 1'b1};
        else
            return {shifted[WIDTH-1:0], quo[WIDTH-2:0], 1'b0};
    endfunction

    // The first step happens on the start edge, so the final bit lands after
    // WIDTH-1 further cycles and done is high in the WIDTH-th busy cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start) begin
            {rem_q, quo_q} <= div_step('0, dividend, divisor);
            dvs_q          <= divisor;
            cnt_q          <= CW'(WIDTH - 1);
            busy_q         <= 1'b1;
        end else if (busy_q) begin
            if (cnt_q != '0) begin
                {rem_q, quo_q} <= div_step(rem_q, quo_q, dvs_q);
                cnt_q          <= cnt_q - 1'b1;
            end else begin
                busy_q <= 1'b0;
            end
        end
    end

    assign done      = busy_q && (cnt_q == '0);
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ops registered directly, divide/modulus via alu_div.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_mc_if.slave  bus
);
    state_t           state;
    state_t           state_n;
    logic [2:0]       op_q;
    logic [WIDTH:0]   result_q;
    logic             div0_q;
    logic [WIDTH:0]   alu_res;
    logic             accept;
    logic             is_div;
    logic             b_zero;
    logic             div_start;
    logic             div_done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    assign bus.in_ready = (state == IDLE) || (state == DONE && bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign is_div       = (bus.sel == OP_DIV) || (bus.sel == OP_MOD);
    assign b_zero       = (bus.b == '0);
    assign div_start    = accept && is_div && !b_zero;

    alu_div #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_start),
        .dividend  (bus.a),
        .divisor   (bus.b),
        .done      (div_done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    // Divide/modulus reach here only with b == 0, where the result is 0.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        alu_res = '0;
        case (bus.sel)
            OP_PASS: alu_res = {1'b0, bus.a};
            OP_ADD:  alu_res = {1'b0, bus.a} + {1'b0, bus.b};
            OP_SUB:  alu_res = {1'b0, bus.a} - {1'b0, bus.b};
            OP_DIV:  alu_res = '0;
            OP_MOD:  alu_res = '0;
            OP_SHL:  alu_res = {bus.a, 1'b0};
            OP_SHR:  alu_res = {2'b00, bus.a[WIDTH-1:1]};
            OP_GT:   alu_res = {{WIDTH{1'b0}}, bus.a > bus.b};
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE: begin
                if (accept)
                    state_n = div_start ? DIV : DONE;
                else if (state == DONE && bus.out_ready)
                    state_n = IDLE;
            end
            DIV: begin
                if (div_done)
                    state_n = DONE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            op_q     <= OP_PASS;
            result_q <= '0;
            div0_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state <= state_n;
            if (accept) begin
                op_q <= bus.sel;
                if (!div_start) begin
                    result_q <= alu_res;
                    div0_q   <= is_div && b_zero;
                end
            end else if (state == DIV && div_done) begin
                result_q <= (op_q == OP_MOD) ? {1'b0, remainder} : {1'b0, quotient};
                div0_q   <= 1'b0;
            end
        end
    end

    assign bus.out_valid = (state == DONE);
    assign bus.result    = result_q;
    assign bus.zero      = (result_q == '0);
    assign bus.div0      = div0_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed pins plus random traffic against a latency/queue model.
module tb_alu_mc;
    import alu_pkg::*;

    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    alu_mc_if #(.WIDTH(W)) bus ();

    alu_mc #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic taken straight from the opcode table.
    function automatic logic [W:0] ref_alu(input logic [2:0] op, input int unsigned a, input int unsigned b);
        int unsigned m;
        int unsigned v;
        m = 1 << (W + 1);
        case (op)
            3'd0:    v = a;
            3'd1:    v = a + b;
            3'd2:    v = (a + m - b) % m;
            3'd3:    v = (b == 0) ? 0 : a / b;
            3'd4:    v = (b == 0) ? 0 : a % b;
            3'd5:    v = a * 2;
            3'd6:    v = a / 2;
            default: v = (a > b) ? 1 : 0;
        endcase
        return (W + 1)'(v);
    endfunction

    // Behavioural model: a result is pending for some cycles, then visible until taken.
    logic       m_valid;
    logic       m_busy;
    int         m_wait;
    logic [W:0] m_res;
    logic       m_div0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_busy  <= 1'b0;
            m_wait  <= 0;
            m_res   <= '0;
            m_div0  <= 1'b0;
        end else begin : model_step
            automatic logic       v   = m_valid;
            automatic logic       bz  = m_busy;
            automatic int         w   = m_wait;
            automatic logic [W:0] r   = m_res;
            automatic logic       d   = m_div0;
            automatic logic       rdy = (!m_busy && !m_valid) || (m_valid && bus.out_ready);
            automatic logic       dv  = (bus.sel == OP_DIV) || (bus.sel == OP_MOD);
            if (v && bus.out_ready) v = 1'b0;
            if (bz) begin
                w = w - 1;
                if (w == 0) begin
                    bz = 1'b0;
                    v  = 1'b1;
                end
            end
            if (bus.in_valid && rdy) begin
                r = ref_alu(bus.sel, bus.a, bus.b);
                d = dv && (bus.b == 0);
                if (dv && bus.b != 0) begin
                    bz = 1'b1;
                    w  = W;
                    v  = 1'b0;
                end else begin
                    v = 1'b1;
                end
            end
            m_valid <= v;
            m_busy  <= bz;
            m_wait  <= w;
            m_res   <= r;
            m_div0  <= d;
        end
    end

    // Compare process: mid-cycle, every cycle out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            check("out_valid", bus.out_valid, m_valid);
            check("in_ready", bus.in_ready, (!m_busy && !m_valid) || (m_valid && bus.out_ready));
            if (m_valid) begin
                check("result", bus.result, m_res);
                check("zero", bus.zero, m_res == 0);
                check("div0", bus.div0, m_div0);
            end
        end
    end

    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic rdy, output int lat, output logic [W:0] res,
                          output logic zf, output logic dz);
        @(posedge clk);
        #2;
        bus.in_valid  = 1'b1;
        bus.sel       = op;
        bus.a         = a;
        bus.b         = b;
        bus.out_ready = rdy;
        @(negedge clk);
        check("in_ready_at_issue", bus.in_ready, 1'b1);
        @(posedge clk);
        #2;
        bus.in_valid = 1'b0;
        bus.a        = W'($urandom);
        bus.b        = W'($urandom);
        bus.sel      = 3'($urandom_range(0, 7));
        lat = 0;
        forever begin
            @(negedge clk);
            lat++;
            if (bus.out_valid) break;
            check("in_ready_busy", bus.in_ready, 1'b0);
            if (lat >= 100) begin
                check("out_valid_timeout", 1'b0, 1'b1);
                break;
            end
        end
        res = bus.result;
        zf  = bus.zero;
        dz  = bus.div0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         lat;
        logic [W:0] res;
        logic       zf;
        logic       dz;

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.sel       = OP_PASS;
        bus.out_ready = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_result", bus.result, 9'h000);
        check("rst_zero", bus.zero, 1'b1);
        check("rst_div0", bus.div0, 1'b0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_rst", bus.in_ready, 1'b1);

        check("model_add", ref_alu(OP_ADD, 200, 100), 9'h12C);
        check("model_sub", ref_alu(OP_SUB, 5, 7), 9'h1FE);
        check("model_div", ref_alu(OP_DIV, 200, 7), 9'd28);
        check("model_mod", ref_alu(OP_MOD, 200, 7), 9'd4);

        run_op(OP_ADD, 8'd200, 8'd100, 1'b1, lat, res, zf, dz);
        check("add_lat", 64'(lat), 64'd1);
        check("add_res", res, 9'h12C);
        check("add_zero", zf, 1'b0);

        run_op(OP_SUB, 8'd5, 8'd7, 1'b1, lat, res, zf, dz);
        check("sub_neg_res", res, 9'h1FE);
        run_op(OP_SUB, 8'd7, 8'd7, 1'b1, lat, res, zf, dz);
        check("sub_eq_res", res, 9'h000);
        check("sub_eq_zero", zf, 1'b1);

        run_op(OP_DIV, 8'd200, 8'd7, 1'b1, lat, res, zf, dz);
        check("div_lat", 64'(lat), 64'd9);
        check("div_res", res, 9'd28);
        check("div_div0", dz, 1'b0);
        run_op(OP_MOD, 8'd200, 8'd7, 1'b1, lat, res, zf, dz);
        check("mod_lat", 64'(lat), 64'd9);
        check("mod_res", res, 9'd4);

        run_op(OP_DIV, 8'd55, 8'd0, 1'b1, lat, res, zf, dz);
        check("div0_lat", 64'(lat), 64'd1);
        check("div0_res", res, 9'd0);
        check("div0_flag", dz, 1'b1);
        run_op(OP_ADD, 8'd1, 8'd1, 1'b1, lat, res, zf, dz);
        check("add11_res", res, 9'd2);
        check("add11_div0", dz, 1'b0);

        // Hold a result, then chain a shift into the handover cycle.
        run_op(OP_ADD, 8'd3, 8'd4, 1'b0, lat, res, zf, dz);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", bus.out_valid, 1'b1);
            check("hold_res", bus.result, 9'd7);
            check("hold_in_ready", bus.in_ready, 1'b0);
        end
        @(posedge clk);
        #2;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.sel       = OP_SHL;
        bus.a         = 8'h81;
        @(posedge clk);
        #2 bus.in_valid = 1'b0;
        @(negedge clk);
        check("b2b_valid", bus.out_valid, 1'b1);
        check("b2b_res", bus.result, 9'h102);

        // Reset in the 4th DIV cycle abandons the divide.
        @(posedge clk);
        #2;
        bus.in_valid = 1'b1;
        bus.sel      = OP_DIV;
        bus.a        = 8'd200;
        bus.b        = 8'd7;
        @(posedge clk);
        #2 bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid", bus.out_valid, 1'b0);
        check("midrst_zero", bus.zero, 1'b1);
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("postrst_valid", bus.out_valid, 1'b0);
            check("postrst_ready", bus.in_ready, 1'b1);
        end

        // Random traffic: the compare process checks every cycle.
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #2;
            bus.in_valid  = ($urandom_range(0, 9) < 6);
            bus.a         = W'($urandom);
            bus.b         = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            bus.sel       = 3'($urandom_range(0, 7));
            bus.out_ready = ($urandom_range(0, 9) < 7);
        end
        @(posedge clk);
        #2;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (20) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  request present on a, b, sel.
REQ-005 in_ready  output  1  block accepts request this cycle.
REQ-006 a  input  WIDTH  operand A, unsigned.
REQ-007 b  input  WIDTH  operand B, unsigned.
REQ-008 sel  input  3  operation code.
REQ-009 out_valid  output  1  result, zero, div0 valid.
REQ-010 out_ready  input  1  consumer takes result this cycle.
REQ-011 result  output  WIDTH+1  operation result.
REQ-012 zero  output  1  result == 0.
REQ-013 div0  output  1  divide/modulus issued with b == 0.

Function
REQ-014 Request accepted in cycle where in_valid && in_ready; a, b, sel captured in registers; later input changes do not affect the operation in flight.
REQ-015 Opcodes: 000 {0,a}; 001 a+b with carry in bit WIDTH; 010 a-b modulo 2^(WIDTH+1), bit WIDTH = borrow; 011 a/b; 100 a%b; 101 {a,1'b0}; 110 {0,a>>1}; 111 1 if a>b else 0.
REQ-016 FSM states IDLE, DIV, DONE; in_ready = (state==IDLE) || (state==DONE && out_ready).
REQ-017 IDLE: on accept of non-divide op, or divide/modulus with b==0 -> DONE; divide/modulus with b!=0 -> DIV; else stay.
REQ-018 Non-divide ops and b==0 cases: out_valid asserted the cycle after acceptance (latency 1).
REQ-019 DIV: restoring shift-subtract, one quotient bit per cycle, exactly WIDTH cycles, then DONE; out_valid asserted WIDTH+1 cycles after acceptance.
REQ-020 Divide result {0,quotient}; modulus result {0,remainder}; b==0 gives result 0, div0=1; div0=0 for all other completions.
REQ-021 DONE: out_valid=1; result, zero, div0 held stable until out_ready sampled high.
REQ-022 DONE with out_ready=1 and in_valid=0 -> IDLE, out_valid low next cycle.
REQ-023 DONE with out_ready=1 and in_valid=1: new request accepted same cycle, transition as from IDLE; non-divide result appears next cycle with out_valid staying high (back-to-back, one op per cycle).
REQ-024 in_valid ignored during DIV; sel values are exhaustive, no illegal opcodes.
REQ-025 zero derived from registered result, never from live inputs.

Reset
REQ-026 rst_n low asynchronously forces state IDLE, out_valid=0, result=0, zero=1, div0=0, divider registers 0.
REQ-027 Reset asserted mid-DIV or mid-DONE abandons the operation; no result emitted after release.
REQ-028 in_ready=1 the first cycle after rst_n deasserts.

Structure
REQ-029 Shared package alu_pkg holds opcode constants (OP_PASS, OP_ADD, OP_SUB, OP_DIV, OP_MOD, OP_SHL, OP_SHR, OP_GT) and the FSM state type.
REQ-030 Iterative divider is sub-module alu_div (start, dividend, divisor -> done, quotient, remainder), parametrised by WIDTH.
REQ-031 Single-cycle ops are a combinational case block in alu_mc feeding the result register.

Verification
REQ-032 WIDTH=8, add a=200 b=100, out_ready=1 -> one cycle later out_valid, result=300 (9'h12C), zero=0.
REQ-033 Sub a=5 b=7 -> result=9'h1FE; sub a=7 b=7 -> result=0, zero=1.
REQ-034 Div a=200 b=7 -> out_valid exactly 9 cycles after accept, result=28; mod same operands -> result=4; in_ready=0 throughout DIV.
REQ-035 Div a=55 b=0 -> latency 1, result=0, div0=1; following add 1+1 -> result=2, div0=0.
REQ-036 out_ready held low 5 cycles in DONE -> result stable, in_ready=0; then out_ready=1 with in_valid=1 (shl a=8'h81) -> next cycle result=9'h102, out_valid stays high.
REQ-037 rst_n pulsed low at 4th cycle of DIV -> out_valid=0 immediately, no result after release, in_ready=1.
